// File: rtl/d2_ag_latch.sv
// D2 -> AG pipeline latch: one main register plus a one-entry skid buffer,
// registered ready toward D2, whole-latch flush, saturating AG-stall counter.
module d2_ag_latch #(
    parameter int W     = 325,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             V_D2,
    input  logic [W-1:0]     D2_PAYLOAD,
    output logic             D2_READY,
    input  logic             AG_STALL,
    input  logic             FLUSH,
    output logic             V_AG,
    output logic [W-1:0]     AG_PAYLOAD,
    output logic [1:0]       OCCUPANCY,
    output logic [CNT_W-1:0] STALL_CNT
);

    // Encoding is {MV, SV} so the valid bits fall straight out of the state.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b10,
        TWO   = 2'b11
    } state_t;

    state_t             state_q, state_d;
    logic [W-1:0]       main_q, main_d;
    logic [W-1:0]       skid_q, skid_d;
    logic               rdy_q, rdy_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               mv, acc, cons;

    assign mv   = state_q[1];
    assign acc  = V_D2 & rdy_q;
    assign cons = mv & ~AG_STALL;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            EMPTY: begin
                if (acc) begin
                    state_d = ONE;
                    main_d  = D2_PAYLOAD;
                end
            end
            ONE: begin
                if (cons && acc) begin
                    main_d = D2_PAYLOAD;
                end else if (cons) begin
                    state_d = EMPTY;
                end else if (acc) begin
                    state_d = TWO;
                    skid_d  = D2_PAYLOAD;
                end
            end
            TWO: begin
                if (cons) begin
                    state_d = ONE;
                    main_d  = skid_q;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (mv && AG_STALL && !(&cnt_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        // Flush drops held entries but leaves payload registers untouched.
        if (FLUSH) begin
            state_d = EMPTY;
            main_d  = main_q;
            skid_d  = skid_q;
            cnt_d   = cnt_q;
        end
        rdy_d = (state_d != TWO);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            rdy_q   <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            rdy_q   <= rdy_d;
            cnt_q   <= cnt_d;
        end
    end

    assign D2_READY   = rdy_q;
    assign V_AG       = mv;
    assign AG_PAYLOAD = main_q;
    assign OCCUPANCY  = {1'b0, state_q[1]} + {1'b0, state_q[0]};
    assign STALL_CNT  = cnt_q;

endmodule

// File: tb/tb_d2_ag_latch.sv
// Bench for d2_ag_latch: directed scenarios followed by random traffic,
// compared each cycle against an in-order queue model.
module tb_d2_ag_latch;

    localparam int W     = 325;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             V_D2;
    logic [W-1:0]     D2_PAYLOAD;
    logic             D2_READY;
    logic             AG_STALL;
    logic             FLUSH;
    logic             V_AG;
    logic [W-1:0]     AG_PAYLOAD;
    logic [1:0]       OCCUPANCY;
    logic [CNT_W-1:0] STALL_CNT;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] q[$];
    logic [W-1:0] m_main = '0;
    bit           m_rdy  = 1'b1;
    int           m_cnt  = 0;

    d2_ag_latch #(.W(W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .V_D2       (V_D2),
        .D2_PAYLOAD (D2_PAYLOAD),
        .D2_READY   (D2_READY),
        .AG_STALL   (AG_STALL),
        .FLUSH      (FLUSH),
        .V_AG       (V_AG),
        .AG_PAYLOAD (AG_PAYLOAD),
        .OCCUPANCY  (OCCUPANCY),
        .STALL_CNT  (STALL_CNT)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] mk(input logic [31:0] eip);
        logic [W-1:0] p;
        p = '0;
        for (int i = 0; i < 11; i++) p = {p[W-33:0], 32'($urandom)};
        p[W-1 -: 32] = eip;
        return p;
    endfunction

    task automatic chk1(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit v, input logic [31:0] eip, input bit st,
                        input bit fl, input bit rs);
        logic [W-1:0] p;
        bit acc, cons;
        p = mk(eip);
        @(negedge clk);
        V_D2 = v; D2_PAYLOAD = p; AG_STALL = st; FLUSH = fl; reset = rs;
        @(posedge clk);
        acc  = v && m_rdy;
        cons = (q.size() > 0) && !st;
        if (rs) begin
            q.delete(); m_main = '0; m_rdy = 1'b1; m_cnt = 0;
        end else begin
            if (q.size() > 0 && st && !fl && m_cnt < (1 << CNT_W) - 1) m_cnt++;
            if (fl) begin
                q.delete();
            end else begin
                if (cons) void'(q.pop_front());
                if (acc) q.push_back(p);
            end
            if (q.size() > 0) m_main = q[0];
            m_rdy = (q.size() < 2);
        end
        #1;
        chk1("d2_ready", 64'(D2_READY), 64'(m_rdy));
        chk1("v_ag", 64'(V_AG), 64'(q.size() > 0));
        chk1("occupancy", 64'(OCCUPANCY), 64'(q.size()));
        chk1("stall_cnt", 64'(STALL_CNT), 64'(m_cnt));
        checks++;
        assert (AG_PAYLOAD === m_main) else begin
            errors++;
            $error("FAIL ag_payload observed_eip=%0h expected_eip=%0h",
                   AG_PAYLOAD[W-1 -: 32], m_main[W-1 -: 32]);
        end
    endtask

    initial begin
        reset = 1'b1; V_D2 = 1'b0; D2_PAYLOAD = '0; AG_STALL = 1'b0; FLUSH = 1'b0;
        // reset then stream
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(1, 32'h1000, 0, 0, 0);
        step(1, 32'h1003, 0, 0, 0);
        step(1, 32'h1007, 0, 0, 0);
        chk1("stream_last_eip", 64'(AG_PAYLOAD[W-1 -: 32]), 64'h1007);
        step(0, 0, 0, 0, 0);
        // skid fill and drain
        step(1, 32'h2000, 1, 0, 0);
        step(1, 32'h2004, 1, 0, 0);
        step(1, 32'h2008, 1, 0, 0);
        chk1("skid_hold_eip", 64'(AG_PAYLOAD[W-1 -: 32]), 64'h2000);
        step(1, 32'h2008, 0, 0, 0);
        chk1("drain_eip", 64'(AG_PAYLOAD[W-1 -: 32]), 64'h2004);
        step(1, 32'h2008, 0, 0, 0);
        chk1("drain_eip2", 64'(AG_PAYLOAD[W-1 -: 32]), 64'h2008);
        step(0, 0, 0, 0, 0);
        // flush in TWO with V_D2 high
        step(1, 32'h3000, 1, 0, 0);
        step(1, 32'h3004, 1, 0, 0);
        step(1, 32'h3008, 1, 1, 0);
        step(0, 0, 0, 0, 0);
        // stall counter: 5 cycles, then saturation
        step(0, 0, 0, 0, 1);
        step(1, 32'h4000, 1, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 0);
        chk1("stall_cnt5", 64'(STALL_CNT), 64'd5);
        for (int i = 0; i < 20; i++) step(0, 0, 1, 0, 0);
        chk1("stall_sat", 64'(STALL_CNT), 64'd15);
        // reset mid-operation in TWO
        step(1, 32'h5000, 1, 0, 0);
        step(0, 0, 1, 0, 1);
        step(1, 32'h6000, 0, 0, 0);
        chk1("post_reset_eip", 64'(AG_PAYLOAD[W-1 -: 32]), 64'h6000);
        // random traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 3) != 0), 32'($urandom),
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 24) == 0),
                 ($urandom_range(0, 99) == 0));
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/d2_ag_latch.md
Name: d2_ag_latch

Overview:
- Pipeline latch between decode stage 2 (D2) and the address-generation (AG) stage.
- Captures the full D2 output bundle (EIP, CS, control store, offset, immediate/displacement, register IDs, AG/ME/EX/WB control bits) into one packed payload.
- Uses a valid/stall handshake with a one-entry skid buffer, so D2 sees a registered ready.
- Supports whole-latch flush from later stages and keeps a saturating AG-stall performance counter.

Parameters:
- W, 325: packed payload width. Layout, MSB to LSB:
  - EIP[31:0], CS[15:0], CONTROL_STORE[127:0], offset[47:0]
  - DATA_SIZE[1:0], SR1_NEEDED, SEG1_NEEDED, MM1_NEEDED, MEM_RD, MEM_WR, ALUK[2:0], LD_GPR1, LD_MM
  - SR1, SR2, SR3, SR4, SEG1, SEG2 (3 bits each)
  - IMM32, DISP32
  - SIB_EN, DISP_EN, BASE_REG_EN, MUX_SEG, CMPXCHG, SIB_S[1:0]
- CNT_W, 16: width of the stall performance counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- V_D2  input  1  D2 holds a valid decoded instruction this cycle
- D2_PAYLOAD  input  W  packed D2 outputs, layout per W
- D2_READY  output  1  latch can accept; driven directly from a flop (skid empty)
- AG_STALL  input  1  AG cannot consume the presented instruction this cycle
- FLUSH  input  1  squash everything held (branch mispredict / exception / far jump)
- V_AG  output  1  AG_PAYLOAD is valid
- AG_PAYLOAD  output  W  payload presented to AG; held stable while V_AG=1 and AG_STALL=1
- OCCUPANCY  output  2  number of instructions held (0, 1 or 2)
- STALL_CNT  output  CNT_W  cycles with V_AG=1 and AG_STALL=1, saturating

Behaviour:
- Storage: main register (MAIN, valid MV) drives AG_PAYLOAD/V_AG. Skid register (SKID, valid SV) is internal.
- Transfers, evaluated each cycle:
  - acc = V_D2 & D2_READY (D2 → latch)
  - cons = MV & ~AG_STALL (latch → AG)
- States: EMPTY (MV=0,SV=0), ONE (MV=1,SV=0), TWO (MV=1,SV=1). MV=0,SV=1 is illegal and must never occur.
- Transitions when FLUSH=0:
  - EMPTY: acc → ONE, MAIN<=D2_PAYLOAD; else stay.
  - ONE:
    - cons & acc → ONE, MAIN<=D2_PAYLOAD
    - cons & ~acc → EMPTY
    - ~cons & acc → TWO, SKID<=D2_PAYLOAD
    - else stay
  - TWO (D2_READY=0, so acc=0):
    - cons → ONE, MAIN<=SKID, SV<=0
    - else stay
- D2_READY <= next-state SV==0. It is registered, so D2 observes backpressure one cycle after the skid fills. The skid absorbs exactly that one instruction.
- Outputs: V_AG=MV, OCCUPANCY=MV+SV, AG_PAYLOAD=MAIN. No combinational path from V_D2 or D2_PAYLOAD to any output.
- FLUSH (highest priority after reset):
  - Next cycle MV=0, SV=0, D2_READY=1. Payload registers are not cleared.
  - An acc in the flush cycle is discarded.
  - A cons in the flush cycle is still counted as transferred by AG (AG owns that decision).
- STALL_CNT:
  - Increments by 1 when MV=1 and AG_STALL=1 and FLUSH=0.
  - Saturates at all-ones and does not wrap.
  - Cleared only by reset.
- Reset (synchronous, dominates FLUSH and handshakes): MV=0, SV=0, D2_READY=1, MAIN=0, SKID=0, STALL_CNT=0, OCCUPANCY=0.
- Latency: an instruction accepted in cycle N appears on AG_PAYLOAD with V_AG=1 in cycle N+1 if the latch was EMPTY or ONE-with-cons.
- Ordering: strictly in order; SKID is never presented before MAIN.
- AG_STALL is ignored when MV=0 (no count, no state change).

Test Plan:
- Reset then stream: reset=1 for 2 cycles, then V_D2=1 with payload EIP field 0x1000, 0x1003, 0x1007, AG_STALL=0 → V_AG=1 from cycle 1 after first accept; AG_PAYLOAD EIP sequence 0x1000, 0x1003, 0x1007 on consecutive cycles; OCCUPANCY=1; D2_READY stays 1.
- Skid fill: hold AG_STALL=1 with V_D2=1 (EIPs 0x2000, 0x2004, 0x2008) → OCCUPANCY goes 1 then 2; D2_READY=0 the cycle after the second accept; 0x2008 is not accepted; AG_PAYLOAD holds 0x2000.
- Skid drain: from TWO, release AG_STALL → AG sees 0x2000, then 0x2004, then 0x2008; no loss or duplication; D2_READY returns to 1 one cycle after SKID moves to MAIN.
- Flush in TWO with V_D2=1 → next cycle V_AG=0, OCCUPANCY=0, D2_READY=1; flushed payloads never appear with V_AG=1.
- Stall counter: MV=1, AG_STALL=1 for 5 cycles → STALL_CNT=5; with CNT_W=4, 20 stall cycles → STALL_CNT=15 (saturated); reset → 0.
- Reset mid-operation in TWO with AG_STALL=1 → next cycle all outputs at reset values; next V_D2 accepted normally.
